// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps every input vector of a small combinational DUT in
// ascending order. Each vector is held for SETTLE cycles plus one sample cycle.
// The block captures the DUT's 1-bit response for each vector, compares it with
// the EXPECTED truth table, and keeps a mismatch count and the lowest failing
// vector.
module truth_table_checker #(
  parameter int          WIDTH    = 5,             // 1..5
  parameter int          SETTLE   = 4,             // >= 1
  parameter logic [31:0] EXPECTED = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [WIDTH-1:0]       vec,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(1<<WIDTH)-1:0]  captured,
  output logic [WIDTH:0]         mismatch_cnt,
  output logic [WIDTH-1:0]       first_fail,
  output logic                   fail_valid
);

  localparam int               N        = 1 << WIDTH;
  localparam int               CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(SETTLE - 1);
  localparam logic [WIDTH-1:0] VEC_LAST = {WIDTH{1'b1}};
  // Only the low 2^WIDTH bits of the table describe real vectors.
  localparam logic [N-1:0]     EXP_TBL  = EXPECTED[N-1:0];

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  vec_q,   vec_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic [N-1:0]      cap_q,   cap_d;
  logic [WIDTH:0]    mcnt_q,  mcnt_d;
  logic [WIDTH-1:0]  ff_q,    ff_d;
  logic              fv_q,    fv_d;
  logic              miss;

  // State and result registers; reset clears everything, including partial sweeps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      cap_q   <= '0;
      mcnt_q  <= '0;
      ff_q    <= '0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      mcnt_q  <= mcnt_d;
      ff_q    <= ff_d;
      fv_q    <= fv_d;
    end
  end

  // Next-state logic: sweep sequencing plus result accumulation in the sample cycle.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    mcnt_d  = mcnt_q;
    ff_d    = ff_q;
    fv_d    = fv_q;
    miss    = (dut_out != EXP_TBL[vec_q]);

    unique case (state_q)
      // A restart from DONE behaves exactly like a start from IDLE.
      S_IDLE, S_DONE: begin
        if (start) begin
          cap_d   = '0;
          mcnt_d  = '0;
          ff_d    = '0;
          fv_d    = 1'b0;
          vec_d   = '0;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end

      // Hold the vector steady; the counter reaches SETTLE-1 on the last settle cycle.
      S_SETTLE: begin
        if (cnt_q == CNT_LAST) state_d = S_SAMPLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end

      // Sample, score, then either advance or stop on the all-ones vector (no wrap).
      S_SAMPLE: begin
        cap_d[vec_q] = dut_out;
        if (miss) begin
          mcnt_d = mcnt_q + 1'b1;
          if (!fv_q) begin
            ff_d = vec_q;
            fv_d = 1'b1;
          end
        end
        if (vec_q == VEC_LAST) begin
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + 1'b1;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decode straight from the state register.
  always_comb begin
    busy = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    done = (state_q == S_DONE);
    pass = done && (mcnt_q == '0);
  end

  assign vec          = vec_q;
  assign captured     = cap_q;
  assign mismatch_cnt = mcnt_q;
  assign first_fail   = ff_q;
  assign fail_valid   = fv_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: three instances with different tables and settle
// times, random DUT response tables, and a loop-based reference model.
module tb_truth_table_checker;
  localparam int          W     = 5;
  localparam int          N     = 32;
  localparam logic [31:0] EXP_A = 32'hA5C3_0F96;
  localparam logic [31:0] EXP_B = 32'h0000_FFFF;
  localparam logic [31:0] EXP_C = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: default table A5C3_0F96, SETTLE=4
  logic start_a = 1'b0;
  logic [31:0] resp_a = '0;
  logic [W-1:0] vec_a, ff_a;
  logic dut_a, busy_a, done_a, pass_a, fv_a;
  logic [N-1:0] cap_a;
  logic [W:0] mc_a;
  assign dut_a = resp_a[vec_a];

  truth_table_checker #(.WIDTH(W), .SETTLE(4), .EXPECTED(EXP_A)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .vec(vec_a), .dut_out(dut_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .captured(cap_a),
    .mismatch_cnt(mc_a), .first_fail(ff_a), .fail_valid(fv_a));

  // Instance B: table 0000_FFFF, SETTLE=2
  logic start_b = 1'b0;
  logic [31:0] resp_b = '0;
  logic [W-1:0] vec_b, ff_b;
  logic dut_b, busy_b, done_b, pass_b, fv_b;
  logic [N-1:0] cap_b;
  logic [W:0] mc_b;
  assign dut_b = resp_b[vec_b];

  truth_table_checker #(.WIDTH(W), .SETTLE(2), .EXPECTED(EXP_B)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .vec(vec_b), .dut_out(dut_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .captured(cap_b),
    .mismatch_cnt(mc_b), .first_fail(ff_b), .fail_valid(fv_b));

  // Instance C: all-zero table, DUT stuck at 1
  logic start_c = 1'b0;
  logic [W-1:0] vec_c, ff_c;
  logic busy_c, done_c, pass_c, fv_c;
  logic [N-1:0] cap_c;
  logic [W:0] mc_c;

  truth_table_checker #(.WIDTH(W), .SETTLE(4), .EXPECTED(EXP_C)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .vec(vec_c), .dut_out(1'b1),
    .busy(busy_c), .done(done_c), .pass(pass_c), .captured(cap_c),
    .mismatch_cnt(mc_c), .first_fail(ff_c), .fail_valid(fv_c));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Reference: score a response table against an expected table.
  task automatic model(input logic [31:0] resp, input logic [31:0] exp,
                       output int mc, output int ff, output bit fv);
    mc = 0; ff = 0; fv = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (resp[i] != exp[i]) begin
        mc++;
        if (!fv) begin fv = 1'b1; ff = i; end
      end
    end
  endtask

  // Full sweep on instance A; optionally pulses start again when vec reaches poke.
  task automatic sweep_a(input string tag, input int poke);
    int k, mc, ff;
    bit fv, poked;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    chk({tag, ".done_at_start"}, done_a, 0);
    chk({tag, ".pass_at_start"}, pass_a, 0);
    chk({tag, ".busy_at_start"}, busy_a, 1);
    chk({tag, ".fv_at_start"}, fv_a, 0);
    chk({tag, ".mc_at_start"}, mc_a, 0);
    chk({tag, ".cap_at_start"}, cap_a, 0);
    k = 0; poked = 1'b0;
    while (!done_a && k < 2000) begin
      start_a = (poke >= 0) && !poked && (int'(vec_a) == poke);
      if (start_a) poked = 1'b1;
      @(posedge clk); #1; start_a = 1'b0;
      k++;
    end
    chk({tag, ".latency"}, k, 160);
    chk({tag, ".busy_at_done"}, busy_a, 0);
    model(resp_a, EXP_A, mc, ff, fv);
    chk({tag, ".captured"}, cap_a, resp_a);
    chk({tag, ".mismatch_cnt"}, mc_a, mc);
    chk({tag, ".fail_valid"}, fv_a, fv);
    chk({tag, ".pass"}, pass_a, (mc == 0));
    if (fv) chk({tag, ".first_fail"}, ff_a, ff);
    chk({tag, ".vec_held"}, vec_a, N - 1);
  endtask

  initial begin
    int k, mc, ff;
    bit fv;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.vec", vec_a, 0);
    chk("rst.busy", busy_a, 0);
    chk("rst.done", done_a, 0);
    chk("rst.pass", pass_a, 0);
    chk("rst.captured", cap_a, 0);
    chk("rst.mc", mc_a, 0);
    chk("rst.ff", ff_a, 0);
    chk("rst.fv", fv_a, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Matching model
    resp_a = EXP_A;
    sweep_a("match", -1);

    // Random response tables; one sweep also gets a stray start at vec 3
    for (int i = 0; i < 4; i++) begin
      resp_a = $urandom;
      sweep_a($sformatf("rand%0d", i), (i == 1) ? 3 : -1);
    end

    // Restart from DONE: failing sweep followed by a matching one
    resp_a = EXP_A ^ 32'h0001_0040;
    sweep_a("restart_fail", -1);
    resp_a = EXP_A;
    sweep_a("restart_pass", -1);

    // Asynchronous reset mid-sweep at vec 10
    resp_a = ~EXP_A;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    k = 0;
    while (vec_a != 5'd10 && k < 500) begin @(posedge clk); #1; k++; end
    chk("midrst.reached_vec10", vec_a, 10);
    rst_n = 1'b0;
    #1;
    chk("midrst.vec", vec_a, 0);
    chk("midrst.busy", busy_a, 0);
    chk("midrst.done", done_a, 0);
    chk("midrst.pass", pass_a, 0);
    chk("midrst.captured", cap_a, 0);
    chk("midrst.mc", mc_a, 0);
    chk("midrst.ff", ff_a, 0);
    chk("midrst.fv", fv_a, 0);
    @(negedge clk); rst_n = 1'b1;
    resp_a = $urandom;
    sweep_a("after_rst", -1);

    // Stuck-at-1 against an all-zero table
    @(negedge clk); start_c = 1'b1;
    @(posedge clk); #1; start_c = 1'b0;
    k = 0;
    while (!done_c && k < 2000) begin @(posedge clk); #1; k++; end
    chk("stuck.latency", k, 160);
    chk("stuck.mc", mc_c, 32);
    chk("stuck.ff", ff_c, 0);
    chk("stuck.fv", fv_c, 1);
    chk("stuck.captured", cap_c, 32'hFFFF_FFFF);
    chk("stuck.pass", pass_c, 0);

    // Single fault at vector 0x13, SETTLE=2 timing checked cycle by cycle
    resp_b = EXP_B ^ (32'h1 << 19);
    @(negedge clk); start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    chk("timing.vec0", vec_b, 0);
    chk("timing.busy0", busy_b, 1);
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      chk($sformatf("timing.vec@%0d", c), vec_b, (c < 96) ? c / 3 : 31);
      chk($sformatf("timing.busy@%0d", c), busy_b, (c < 96));
      chk($sformatf("timing.done@%0d", c), done_b, (c >= 96));
    end
    model(resp_b, EXP_B, mc, ff, fv);
    chk("single.mc", mc_b, mc);
    chk("single.mc_const", mc_b, 1);
    chk("single.ff", ff_b, 5'h13);
    chk("single.fv", fv_b, fv);
    chk("single.captured", cap_b, 32'h0008_FFFF);
    chk("single.pass", pass_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
